// File: rtl/tron_frame_sequencer.sv
// tron_frame_sequencer
//   Only block that drives the shared 160x120 1-bit board RAM and the
//   vga_adapter plot port. Between rounds it sweeps the board, writing the
//   border as occupied and everything else as empty. During a round, each
//   game tick reads both players' next cells, resolves collisions, and then
//   either commits both trail pixels or ends the round.
//
// Ports
//   clk, resetn            system clock, asynchronous active-low reset
//   tick, start            game-step pulse, round start / re-clear pulse
//   p1_x/p1_y, p2_x/p2_y   next cell of each player
//   ram_addr/we/wdata      board RAM port (address = y*H_RES+x)
//   ram_rdata              board RAM read data, one cycle after address
//   vga_x/y/colour/plot    vga_adapter plot port
//   step_ack               tick fully processed without a crash
//   round_over, winner     end-of-round status (01 p1, 10 p2, 11 draw)
//   busy                   low only while ARMED, WAIT_TICK or OVER
//
// Optional build macro TRON_SCORE_EN adds saturating (0..9) win counters
// p1_score/p2_score. These are cleared only by resetn.

module tron_frame_sequencer #(
   parameter int unsigned H_RES         = 160,
   parameter int unsigned V_RES         = 120,
   parameter logic [2:0]  P1_COLOUR     = 3'b101,
   parameter logic [2:0]  P2_COLOUR     = 3'b011,
   parameter logic [2:0]  BORDER_COLOUR = 3'b111,
   parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        tick,
   input  logic        start,
   input  logic [7:0]  p1_x,
   input  logic [7:0]  p1_y,
   input  logic [7:0]  p2_x,
   input  logic [7:0]  p2_y,
   output logic [14:0] ram_addr,
   output logic        ram_we,
   output logic        ram_wdata,
   input  logic        ram_rdata,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        step_ack,
   output logic        round_over,
   output logic [1:0]  winner,
   output logic        busy
`ifdef TRON_SCORE_EN
   ,
   output logic [3:0]  p1_score,
   output logic [3:0]  p2_score
`endif
);

   typedef enum logic [3:0] {
      S_CLEAR, S_ARMED, S_WAIT, S_RD1, S_RD2, S_CHK, S_WR1, S_WR2, S_OVER
   } state_t;

   state_t     state;
   logic [7:0] cx;
   logic [6:0] cy;
   logic [7:0] p1x_q, p1y_q, p2x_q, p2y_q;
   logic       occ1;
   logic       border, last_x, last_y;
   logic       p1_oob, p2_oob, same_cell, c1, c2;

   function automatic logic [14:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
      logic [16:0] a;
      a = 17'(y) * 17'(H_RES) + 17'(x);
      return a[14:0];
   endfunction

   assign last_x    = (cx == 8'(H_RES - 1));
   assign last_y    = (cy == 7'(V_RES - 1));
   assign border    = (cx == '0) || last_x || (cy == '0) || last_y;
   assign p1_oob    = (32'(p1x_q) >= H_RES) || (32'(p1y_q) >= V_RES);
   assign p2_oob    = (32'(p2x_q) >= H_RES) || (32'(p2y_q) >= V_RES);
   assign same_cell = (p1x_q == p2x_q) && (p1y_q == p2y_q);
   // The p2 read data arrives during CHK itself, so it is used directly.
   assign c1        = occ1 | p1_oob | same_cell;
   assign c2        = ram_rdata | p2_oob | same_cell;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_CLEAR;
         cx         <= '0;
         cy         <= '0;
         p1x_q      <= '0;
         p1y_q      <= '0;
         p2x_q      <= '0;
         p2y_q      <= '0;
         occ1       <= 1'b0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         step_ack   <= 1'b0;
         round_over <= 1'b0;
         winner     <= '0;
         busy       <= 1'b0;
`ifdef TRON_SCORE_EN
         p1_score   <= '0;
         p2_score   <= '0;
`endif
      end else begin
         vga_plot  <= 1'b0;
         ram_we    <= 1'b0;
         ram_wdata <= 1'b0;
         step_ack  <= 1'b0;
         case (state)
            S_CLEAR: begin
               busy       <= 1'b1;
               vga_plot   <= 1'b1;
               ram_we     <= 1'b1;
               vga_x      <= cx;
               vga_y      <= cy;
               ram_addr   <= cell_addr(cx, {1'b0, cy});
               ram_wdata  <= border;
               vga_colour <= border ? BORDER_COLOUR : BG_COLOUR;
               if (last_x) begin
                  cx <= '0;
                  if (last_y) begin
                     cy    <= '0;
                     state <= S_ARMED;
                     busy  <= 1'b0;
                  end else begin
                     cy <= cy + 7'd1;
                  end
               end else begin
                  cx <= cx + 8'd1;
               end
            end
            S_ARMED: begin
               if (start) state <= S_WAIT;
            end
            S_WAIT: begin
               if (tick) begin
                  p1x_q    <= p1_x;
                  p1y_q    <= p1_y;
                  p2x_q    <= p2_x;
                  p2y_q    <= p2_y;
                  // Address goes out straight from the inputs so RD1 presents it.
                  ram_addr <= cell_addr(p1_x, p1_y);
                  busy     <= 1'b1;
                  state    <= S_RD1;
               end
            end
            S_RD1: begin
               ram_addr <= cell_addr(p2x_q, p2y_q);
               state    <= S_RD2;
            end
            S_RD2: begin
               occ1  <= ram_rdata;
               state <= S_CHK;
            end
            S_CHK: begin
               if (!c1 && !c2) begin
                  ram_addr   <= cell_addr(p1x_q, p1y_q);
                  ram_we     <= 1'b1;
                  ram_wdata  <= 1'b1;
                  vga_plot   <= 1'b1;
                  vga_x      <= p1x_q;
                  vga_y      <= p1y_q[6:0];
                  vga_colour <= P1_COLOUR;
                  state      <= S_WR1;
               end else begin
                  winner     <= {c1, c2};
                  round_over <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_OVER;
`ifdef TRON_SCORE_EN
                  if (!c1 && p1_score != 4'd9) p1_score <= p1_score + 4'd1;
                  if (!c2 && p2_score != 4'd9) p2_score <= p2_score + 4'd1;
`endif
               end
            end
            S_WR1: begin
               ram_addr   <= cell_addr(p2x_q, p2y_q);
               ram_we     <= 1'b1;
               ram_wdata  <= 1'b1;
               vga_plot   <= 1'b1;
               vga_x      <= p2x_q;
               vga_y      <= p2y_q[6:0];
               vga_colour <= P2_COLOUR;
               step_ack   <= 1'b1;
               state      <= S_WR2;
            end
            S_WR2: begin
               busy  <= 1'b0;
               state <= S_WAIT;
            end
            S_OVER: begin
               if (start) begin
                  winner     <= '0;
                  round_over <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_CLEAR;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_tron_frame_sequencer.sv
// Bench for tron_frame_sequencer: a behavioural board RAM, a scoreboard of
// expected plots (pushed when stimulus is driven, popped on each vga_plot),
// and directed round scenarios.
module tb_tron_frame_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
   logic [14:0] ram_addr;
   logic        ram_we, ram_wdata;
   logic        ram_rdata;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot, step_ack, round_over, busy;
   logic [1:0]  winner;
`ifdef TRON_SCORE_EN
   logic [3:0]  p1_score, p2_score;
`endif

   tron_frame_sequencer dut (
      .clk(clk), .resetn(resetn), .tick(tick), .start(start),
      .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .step_ack(step_ack), .round_over(round_over), .winner(winner), .busy(busy)
`ifdef TRON_SCORE_EN
      , .p1_score(p1_score), .p2_score(p2_score)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Board RAM model: synchronous read, data valid one cycle after address.
   logic        mem [0:19199];
   logic        pre_req = 1'b0;
   logic [14:0] pre_addr = '0;
   always @(posedge clk) begin
      if (pre_req) mem[pre_addr] <= 1'b1;
      if (ram_we && ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
      ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 1'b0;
   end

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] col;
      logic       wd;
      int         cyc;   // -1: cycle not checked
   } plot_t;
   plot_t exp_q[$];

   int plot_cnt = 0;
   int ack_cnt = 0;
   int ack_cyc = -1;

   always @(negedge clk) begin
      plot_t e;
      if (vga_plot) begin
         plot_cnt++;
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_plot: observed plot at (%0d,%0d) expected none", vga_x, vga_y);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("plot_x", 32'(vga_x), 32'(e.x));
            chk("plot_y", 32'(vga_y), 32'(e.y));
            chk("plot_colour", 32'(vga_colour), 32'(e.col));
            chk("plot_we", 32'(ram_we), 32'd1);
            chk("plot_wdata", 32'(ram_wdata), 32'(e.wd));
            chk("plot_addr", 32'(ram_addr), 32'(e.y) * 32'd160 + 32'(e.x));
            if (e.cyc >= 0) chk("plot_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else if (ram_we) begin
         chk("stray_ram_we", 32'(ram_we), 32'd0);
      end
      if (step_ack) begin
         ack_cnt++;
         ack_cyc = cyc;
      end
   end

   task automatic push_clear();
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            plot_t e;
            e.x   = 8'(x);
            e.y   = 7'(y);
            e.wd  = (x == 0) || (x == 159) || (y == 0) || (y == 119);
            e.col = e.wd ? 3'b111 : 3'b000;
            e.cyc = -1;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_plot(input int x, input int y, input logic [2:0] col, input int c);
      plot_t e;
      e.x = 8'(x); e.y = 7'(y); e.col = col; e.wd = 1'b1; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_plots(input int n, input int budget, input string tag);
      int k = 0;
      while (plot_cnt < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(tag, 32'(plot_cnt), 32'(n));
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_tick(output int t);
      @(posedge clk); #1 tick = 1'b1;
      t = cyc;
      @(posedge clk); #1 tick = 1'b0;
   endtask

   task automatic set_players(input int ax, input int ay, input int bx, input int by);
      p1_x = 8'(ax); p1_y = 8'(ay); p2_x = 8'(bx); p2_y = 8'(by);
   endtask

   initial begin
      int t;
      int base;

      // Reset state and first full clear.
      push_clear();
      idle(3);
      chk("rst_plot", 32'(vga_plot), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_over", 32'(round_over), 32'd0);
      chk("rst_ack", 32'(step_ack), 32'd0);
      resetn = 1'b1;
      wait_plots(19200, 19300, "clear1_count");
      idle(3);
      chk("clear1_plots", 32'(plot_cnt), 32'd19200);
      chk("clear1_queue", 32'(exp_q.size()), 32'd0);
      chk("armed_busy", 32'(busy), 32'd0);
      chk("mem_0_0", 32'(mem[0]), 32'd1);
      chk("mem_5_5", 32'(mem[805]), 32'd0);
      chk("mem_159_0", 32'(mem[159]), 32'd1);
      chk("mem_80_119", 32'(mem[119 * 160 + 80]), 32'd1);

      // First legal step.
      pulse_start();
      chk("wait_busy", 32'(busy), 32'd0);
      set_players(6, 5, 111, 111);
      push_plot(6, 5, 3'b101, cyc + 1 + 4);
      push_plot(111, 111, 3'b011, cyc + 1 + 5);
      pulse_tick(t);
      chk("step_busy", 32'(busy), 32'd1);
      idle(8);
      chk("step_plots", 32'(plot_cnt), 32'd19202);
      chk("step_ack_cnt", 32'(ack_cnt), 32'd1);
      chk("step_ack_cycle", 32'(ack_cyc), 32'(t + 5));
      chk("step_mem_p1", 32'(mem[5 * 160 + 6]), 32'd1);
      chk("step_mem_p2", 32'(mem[111 * 160 + 111]), 32'd1);
      chk("step_queue", 32'(exp_q.size()), 32'd0);
      chk("step_over", 32'(round_over), 32'd0);

      // Second tick at T+2 is dropped.
      set_players(7, 6, 112, 111);
      @(posedge clk); #1 tick = 1'b1;
      t = cyc;
      push_plot(7, 6, 3'b101, t + 4);
      push_plot(112, 111, 3'b011, t + 5);
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      idle(12);
      chk("dbl_ack_cnt", 32'(ack_cnt), 32'd2);
      chk("dbl_ack_cycle", 32'(ack_cyc), 32'(t + 5));
      chk("dbl_plots", 32'(plot_cnt), 32'd19204);

      // P1 runs into an occupied cell: player 2 wins.
      @(posedge clk); #1 pre_addr = 15'd807; pre_req = 1'b1;
      @(posedge clk); #1 pre_req = 1'b0;
      set_players(7, 5, 113, 111);
      pulse_tick(t);
      idle(8);
      chk("p1crash_over", 32'(round_over), 32'd1);
      chk("p1crash_winner", 32'(winner), 32'b10);
      chk("p1crash_plots", 32'(plot_cnt), 32'd19204);
      chk("p1crash_ack", 32'(ack_cnt), 32'd2);
      chk("p1crash_busy", 32'(busy), 32'd0);
      chk("p1crash_nowrite", 32'(mem[111 * 160 + 113]), 32'd0);
      pulse_tick(t);
      idle(8);
      chk("over_tick_ignored", 32'(plot_cnt), 32'd19204);
      chk("over_hold_winner", 32'(winner), 32'b10);

      // Re-clear, interrupted by reset around pixel 1000.
      push_clear();
      pulse_start();
      chk("restart_winner", 32'(winner), 32'd0);
      chk("restart_over", 32'(round_over), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      base = plot_cnt;
      wait_plots(base + 1000, 1100, "clear2_partial");
      resetn = 1'b0;
      exp_q.delete();
      push_clear();
      idle(3);
      chk("midrst_plot", 32'(vga_plot), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      base = plot_cnt;
      wait_plots(base + 19200, 19300, "clear3_count");
      idle(3);
      chk("clear3_queue", 32'(exp_q.size()), 32'd0);
      chk("clear3_busy", 32'(busy), 32'd0);

      // Head-on collision: draw, nothing written.
      pulse_start();
      set_players(50, 60, 50, 60);
      base = plot_cnt;
      pulse_tick(t);
      idle(8);
      chk("draw_winner", 32'(winner), 32'b11);
      chk("draw_over", 32'(round_over), 32'd1);
      chk("draw_plots", 32'(plot_cnt), 32'(base));
      chk("draw_nowrite", 32'(mem[60 * 160 + 50]), 32'd0);

      push_clear();
      pulse_start();
      base = plot_cnt;
      wait_plots(base + 19200, 19300, "clear4_count");
      idle(3);

      // P2 hits the right-hand border: player 1 wins.
      pulse_start();
      set_players(20, 20, 159, 40);
      pulse_tick(t);
      idle(8);
      chk("p2crash_winner", 32'(winner), 32'b01);
      chk("p2crash_nowrite", 32'(mem[20 * 160 + 20]), 32'd0);
`ifdef TRON_SCORE_EN
      chk("score_p1", 32'(p1_score), 32'd1);
      chk("score_p2", 32'(p2_score), 32'd0);
`endif
      push_clear();
      pulse_start();
      chk("final_winner", 32'(winner), 32'd0);
      chk("final_over", 32'(round_over), 32'd0);
      idle(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tron_frame_sequencer.md
Name: tron_frame_sequencer

Overview:
- Single owner of the shared 1-bit board RAM (160x120 occupancy map) and the single vga_adapter plot port.
- Per game tick: reads both players' next cells, detects collisions, then writes the trails to RAM and plots them on the VGA.
- Between rounds: sweeps the board to clear it and redraw the border.
- Sits between the per-player direction/position logic and the vga_adapter instance in the top level.

Parameters:
- H_RES, 160, board width in pixels
- V_RES, 120, board height in pixels
- P1_COLOUR, 3'b101, player 1 trail colour
- P2_COLOUR, 3'b011, player 2 trail colour
- BORDER_COLOUR, 3'b111, border pixel colour
- BG_COLOUR, 3'b000, empty pixel colour

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-step pulse from the rate divider
- start  in  1  one-cycle pulse; begins a round from ARMED, or re-clears from OVER
- p1_x  in  8  player 1 next x
- p1_y  in  8  player 1 next y
- p2_x  in  8  player 2 next x
- p2_y  in  8  player 2 next y
- ram_addr  out  15  board RAM address, computed as y*H_RES+x
- ram_we  out  1  board RAM write enable
- ram_wdata  out  1  board RAM write data (1 = occupied)
- ram_rdata  in  1  board RAM read data; valid exactly 1 cycle after ram_addr is presented
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  3  plot colour
- vga_plot  out  1  plot strobe
- step_ack  out  1  one-cycle pulse when a tick has been fully processed without a crash; player logic commits its positions on this pulse
- round_over  out  1  high while in OVER
- winner  out  2  00 none, 01 player 1 wins, 10 player 2 wins, 11 draw
- busy  out  1  high in every state except ARMED, WAIT_TICK and OVER

Behaviour:
- Reset values: all outputs 0; state CLEAR; clear counters cx=0, cy=0. Reset asserted mid-operation aborts the current operation immediately, and clearing restarts from (0,0) when reset is released.
- CLEAR:
  - One pixel per cycle, x as the inner loop; exactly H_RES*V_RES = 19200 cycles.
  - Each cycle drives vga_plot=1, ram_we=1, vga_x=cx, vga_y=cy, ram_addr=cy*160+cx.
  - Border pixels (x==0, x==159, y==0 or y==119): ram_wdata=1, colour BORDER_COLOUR. All other pixels: ram_wdata=0, colour BG_COLOUR.
  - After pixel (159,119), go to ARMED. tick and start are ignored during CLEAR.
- ARMED: start -> WAIT_TICK. tick is ignored.
- WAIT_TICK: tick -> RD1 and latch p1_x, p1_y, p2_x, p2_y into internal registers.
  - Any tick arriving in states other than WAIT_TICK is dropped; there is no queuing.
- RD1: ram_addr = latched p1 address.
- RD2: ram_addr = latched p2 address; capture ram_rdata as occ1.
- CHK: capture ram_rdata as occ2, then compute crash flags.
  - c1 = occ1 OR p1 out of range (x>=160 or y>=120) OR p1 cell == p2 cell.
  - c2 = occ2 OR p2 out of range OR p1 cell == p2 cell.
  - Out-of-range coordinates are never used to write RAM.
  - Neither crashed -> WR1. Otherwise winner = {c1,c2} mapped as: c1 only = 10, c2 only = 01, both = 11; go to OVER. No write or plot occurs on a crash tick.
- WR1: ram_we=1, ram_wdata=1 at the p1 address; vga_plot=1 at p1 with P1_COLOUR.
- WR2: same for p2 with P2_COLOUR; step_ack=1; return to WAIT_TICK.
- Latency: tick at cycle T gives RD1 at T+1, RD2 at T+2, CHK at T+3, p1 plot at T+4, p2 plot and step_ack at T+5.
- OVER: winner and round_over are held. start -> CLEAR and winner resets to 00. tick is ignored.
- Strobes: vga_plot, ram_we and step_ack are low in every state not listed above as driving them.

Optional Feature:
- Macro: TRON_SCORE_EN.
- When defined, the block adds outputs p1_score[3:0] and p2_score[3:0].
  - Both are 0 on reset.
  - On entry to OVER, the winning player's score increments, saturating at 9. A draw increments neither.
  - Scores persist across CLEAR and clear only on resetn.
- When undefined, these ports and their registers do not exist.

Test Plan:
- Release reset -> exactly 19200 vga_plot pulses. Pixel (0,0) is written with 1/3'b111, pixel (5,5) with 0/3'b000, then the block enters ARMED with busy=0.
- start, then tick with p1=(6,5) and p2=(111,111) on empty cells -> plot (6,5) colour 101 at T+4, plot (111,111) colour 011 at T+5, step_ack at T+5, RAM bits at both addresses become 1.
- Preload RAM addr 5*160+7 = 807 to 1, tick with p1=(7,5) -> no plots, round_over=1, winner=10.
- Tick with p1=p2=(50,60) -> winner=11, no writes.
- Tick with p2=(159,40) (border) -> winner=01. Then start -> CLEAR runs 19200 cycles and winner returns to 00.
- Second tick pulse at T+2 is dropped (only one step_ack). Reset asserted at CLEAR pixel 1000 -> after release, clearing restarts at (0,0). With TRON_SCORE_EN, ten p1 wins give p1_score=9.
